// File: rtl/qos_pkg.sv
// rtl/qos_pkg.sv - shared constants and types for the QoS PCIe path
package qos_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int CLASS_MSB  = 9;
  localparam int CLASS_LSB  = 8;
  localparam int NUM_VC     = 4;

  // Default per-VC occupancy thresholds, shared with the weighted arbiter
  localparam int VC_AF_TH = 6;
  localparam int VC_AE_TH = 1;

  typedef enum logic [1:0] {
    VC_P0 = 2'd0,
    VC_P1 = 2'd1,
    VC_P2 = 2'd2,
    VC_P3 = 2'd3
  } vc_class_e;

  function automatic vc_class_e word_class(input logic [DATA_WIDTH-1:0] word);
    return vc_class_e'(word[CLASS_MSB:CLASS_LSB]);
  endfunction

endpackage

// File: rtl/fifo_vc_mem.sv
// rtl/fifo_vc_mem.sv - dual-port register file, synchronous write and registered read
module fifo_vc_mem #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-address read and write (full FIFO, push+pop) returns the old word
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_vc.sv
// rtl/fifo_vc.sv - per-virtual-channel FIFO with registered occupancy flags
// Optional sticky error flags when FIFO_VC_ERR_EN is defined.
module fifo_vc
  import qos_pkg::*;
#(
  parameter int DATA_WIDTH = qos_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_TH      = VC_AF_TH,
  parameter int AE_TH      = VC_AE_TH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
`ifdef FIFO_VC_ERR_EN
  output logic                  almost_full,
  output logic                  err_overflow,
  output logic                  err_underflow
`else
  output logic                  almost_full
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_CNT   = AF_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT   = AE_TH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  push_acc;
  logic                  pop_acc;

  // A full FIFO still accepts a push when the same cycle frees a slot
  assign pop_acc  = reset & pop & (count_q != '0);
  assign push_acc = reset & push & ((count_q != FULL_CNT) | pop_acc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

`ifdef FIFO_VC_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push && !push_acc) begin
        err_overflow <= 1'b1;
      end
      if (pop && !pop_acc) begin
        err_underflow <= 1'b1;
      end
    end
  end
`endif

  fifo_vc_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_vc.sv
// tb/tb_fifo_vc.sv - scoreboard bench for fifo_vc against a queue reference model
module tb_fifo_vc;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] data_out;
  logic        valid_out;
  logic [3:0]  count;
  logic        empty, full, almost_empty, almost_full;
`ifdef FIFO_VC_ERR_EN
  logic        err_overflow, err_underflow;
`endif

  fifo_vc dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
`ifdef FIFO_VC_ERR_EN
    .almost_full  (almost_full),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
`else
    .almost_full  (almost_full)
`endif
  );

  always #5 clk = ~clk;

  logic [11:0] m_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] exp_dout = '0;
  logic        exp_valid = 1'b0;
  logic        exp_ov = 1'b0;
  logic        exp_un = 1'b0;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Drive one cycle and advance the reference model to the post-edge state
  task automatic step(input logic p, input logic q, input logic [11:0] d, input logic r);
    bit pop_ok, push_ok;
    @(negedge clk);
    push = p; pop = q; data_in = d; reset = r;
    chk_en = 1'b1;
    if (!r) begin
      m_q.delete();
      exp_dout = '0; exp_valid = 1'b0; exp_ov = 1'b0; exp_un = 1'b0;
    end else begin
      pop_ok  = q && (m_q.size() > 0);
      push_ok = p && (m_q.size() < DEPTH || pop_ok);
      if (p && !push_ok) exp_ov = 1'b1;
      if (q && !pop_ok) exp_un = 1'b1;
      exp_valid = pop_ok;
      if (pop_ok) begin
        exp_dout = m_q.pop_front();
        exp_q.push_back(exp_dout);
      end
      if (push_ok) m_q.push_back(d);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        check("count", int'(count), m_q.size());
        check("empty", int'(empty), int'(m_q.size() == 0));
        check("full", int'(full), int'(m_q.size() == DEPTH));
        check("almost_full", int'(almost_full), int'(m_q.size() >= AF));
        check("almost_empty", int'(almost_empty), int'(m_q.size() <= AE));
        check("valid_out", int'(valid_out), int'(exp_valid));
        check("data_out", int'(data_out), int'(exp_dout));
        if (valid_out === 1'b1) begin
          if (exp_q.size() == 0) check("sb_unexpected_word", int'(data_out), -1);
          else check("sb_order", int'(data_out), int'(exp_q.pop_front()));
        end
`ifdef FIFO_VC_ERR_EN
        check("err_overflow", int'(err_overflow), int'(exp_ov));
        check("err_underflow", int'(err_underflow), int'(exp_un));
`endif
      end
    end
  end

  initial begin
    logic [11:0] seq3 [3];
    seq3[0] = 12'h0A5; seq3[1] = 12'h1B6; seq3[2] = 12'h2C7;

    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    for (int i = 0; i < 3; i++) step(1, 0, seq3[i], 1);
    for (int i = 0; i < 3; i++) step(0, 1, '0, 1);
    step(0, 0, '0, 1);

    for (int i = 0; i < 8; i++) step(1, 0, 12'h100 + 12'(i), 1);
    step(1, 0, 12'hFFF, 1);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 1);

    step(0, 1, '0, 1);
    step(1, 1, 12'h055, 1);
    step(0, 1, '0, 1);

    step(0, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 12'h200 + 12'(i), 1);
    step(1, 1, 12'h3AA, 1);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 1);

    for (int i = 0; i < 20; i++) begin
      step(1, 0, 12'h400 + 12'(i), 1);
      step(0, 1, '0, 1);
    end

    for (int i = 0; i < 5; i++) step(1, 0, 12'h500 + 12'(i), 1);
    step(0, 0, '0, 0);
    step(0, 1, '0, 1);

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int pp, pq;
      pp = ((i / 150) % 2 == 0) ? 75 : 30;
      pq = ((i / 150) % 2 == 0) ? 30 : 75;
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq,
           12'($urandom_range(0, 4095)), $urandom_range(0, 299) != 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, '0, 1);
    step(0, 0, '0, 1);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
